// File: rtl/sync_fifo_flags.sv
// Single-clock parametrised FIFO with occupancy count, programmable almost-full/empty
// thresholds, sticky overflow/underflow flags and optional first-word-fall-through read.
module sync_fifo_flags #(
    parameter int WIDTH     = 4,
    parameter int DEPTH     = 8,
    parameter int AF_THRESH = DEPTH - 2,
    parameter int AE_THRESH = 2,
    parameter int FWFT      = 0
) (
    input  logic                     clk_in,
    input  logic                     rst_n,
    input  logic                     wr_rq,
    input  logic                     rd_rq,
    input  logic [WIDTH-1:0]         wdata,
    input  logic                     clr_err,
    output logic [WIDTH-1:0]         rdata,
    output logic                     full,
    output logic                     empty,
    output logic                     almost_full,
    output logic                     almost_empty,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     overflow,
    output logic                     underflow
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wptr;
    logic [AW-1:0]    r_rptr;
    logic [CW-1:0]    r_count;
    logic             r_overflow;
    logic             r_underflow;

    logic             w_full;
    logic             w_empty;
    logic             w_wr_acc;
    logic             w_rd_acc;
    logic [CW-1:0]    w_count_next;

    // Flags come purely from the registered count, so they never see wr_rq/rd_rq.
    assign w_full   = (r_count == CW'(DEPTH));
    assign w_empty  = (r_count == '0);
    assign w_wr_acc = wr_rq && !w_full;
    assign w_rd_acc = rd_rq && !w_empty;

    always_comb begin
        w_count_next = r_count;
        case ({w_wr_acc, w_rd_acc})
            2'b10:   w_count_next = r_count + CW'(1);
            2'b01:   w_count_next = r_count - CW'(1);
            default: w_count_next = r_count;
        endcase
    end

    // Storage has no reset so it can map onto RAM primitives.
    always_ff @(posedge clk_in) begin
        if (w_wr_acc) begin
            r_mem[r_wptr] <= wdata;
        end
    end

    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_wr_acc) begin
                r_wptr <= r_wptr + AW'(1);
            end
            if (w_rd_acc) begin
                r_rptr <= r_rptr + AW'(1);
            end
            r_count <= w_count_next;
        end
    end

    // A fresh error on the same edge as clr_err wins, so the flag is never lost.
    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
        end else begin
            if (wr_rq && w_full) begin
                r_overflow <= 1'b1;
            end else if (clr_err) begin
                r_overflow <= 1'b0;
            end
            if (rd_rq && w_empty) begin
                r_underflow <= 1'b1;
            end else if (clr_err) begin
                r_underflow <= 1'b0;
            end
        end
    end

    generate
        if (FWFT != 0) begin : g_fwft
            assign rdata = r_mem[r_rptr];
        end else begin : g_std
            logic [WIDTH-1:0] r_rdata;
            always_ff @(posedge clk_in or negedge rst_n) begin
                if (!rst_n) begin
                    r_rdata <= '0;
                end else if (w_rd_acc) begin
                    r_rdata <= r_mem[r_rptr];
                end
            end
            assign rdata = r_rdata;
        end
    endgenerate

    assign full         = w_full;
    assign empty        = w_empty;
    assign almost_full  = (r_count >= CW'(AF_THRESH));
    assign almost_empty = (r_count <= CW'(AE_THRESH));
    assign count        = r_count;
    assign overflow     = r_overflow;
    assign underflow    = r_underflow;

endmodule

// File: tb/tb_sync_fifo_flags.sv
// Self-checking bench: a standard-read and an FWFT instance share one stimulus stream
// and are compared against a queue-based reference model plus fixed expectation tables.
module tb_sync_fifo_flags;

    logic       clk_in = 1'b0;
    logic       rst_n  = 1'b0;
    logic       wr_rq  = 1'b0;
    logic       rd_rq  = 1'b0;
    logic       clr_err = 1'b0;
    logic [3:0] wdata  = '0;

    logic [3:0] rdata0, rdata1;
    logic       full0, empty0, af0, ae0, ovf0, udf0;
    logic       full1, empty1, af1, ae1, ovf1, udf1;
    logic [3:0] count0, count1;

    int n_tests = 0;
    int n_fail  = 0;

    // reference model
    logic [3:0] m_q[$];
    bit         m_ovf = 0;
    bit         m_udf = 0;
    logic [3:0] m_rdata0 = '0;

    always #5 clk_in = ~clk_in;

    sync_fifo_flags #(.WIDTH(4), .DEPTH(8), .AF_THRESH(6), .AE_THRESH(2), .FWFT(0)) u_std (
        .clk_in(clk_in), .rst_n(rst_n), .wr_rq(wr_rq), .rd_rq(rd_rq), .wdata(wdata),
        .clr_err(clr_err), .rdata(rdata0), .full(full0), .empty(empty0),
        .almost_full(af0), .almost_empty(ae0), .count(count0),
        .overflow(ovf0), .underflow(udf0)
    );

    sync_fifo_flags #(.WIDTH(4), .DEPTH(8), .AF_THRESH(6), .AE_THRESH(2), .FWFT(1)) u_fwft (
        .clk_in(clk_in), .rst_n(rst_n), .wr_rq(wr_rq), .rd_rq(rd_rq), .wdata(wdata),
        .clr_err(clr_err), .rdata(rdata1), .full(full1), .empty(empty1),
        .almost_full(af1), .almost_empty(ae1), .count(count1),
        .overflow(ovf1), .underflow(udf1)
    );

    typedef struct {
        bit         wr;
        bit         rd;
        bit         clr;
        logic [3:0] wd;
        int         cnt;
        bit         full;
        bit         empty;
        bit         af;
        bit         ae;
        bit         ovf;
        bit         udf;
        int         rdata;
    } vec_t;

    vec_t tbl[$];

    task automatic chk(input string nm, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
        end
    endtask

    task automatic model_reset();
        m_q.delete();
        m_ovf    = 0;
        m_udf    = 0;
        m_rdata0 = '0;
    endtask

    // One clock of stimulus: model advances on the same inputs, outputs sampled 1 time unit after the edge.
    task automatic step(input bit wr, input bit rd, input bit clr, input logic [3:0] wd);
        bit wa, ra;
        wr_rq = wr; rd_rq = rd; clr_err = clr; wdata = wd;
        wa = wr && (m_q.size() < 8);
        ra = rd && (m_q.size() > 0);
        if (wr && m_q.size() == 8) m_ovf = 1; else if (clr) m_ovf = 0;
        if (rd && m_q.size() == 0) m_udf = 1; else if (clr) m_udf = 0;
        if (ra) m_rdata0 = m_q.pop_front();
        if (wa) m_q.push_back(wd);
        @(posedge clk_in);
        #1;
        wr_rq = 0; rd_rq = 0; clr_err = 0;
        $display("[TB] wr=%0b rd=%0b clr=%0b wd=%0h -> count=%0d rdata=%0h/%0h ovf=%0b udf=%0b",
                 wr, rd, clr, wd, count0, rdata0, rdata1, ovf0, udf0);
    endtask

    task automatic check_model(input string tag);
        int c;
        c = m_q.size();
        chk({tag, ".count"},  int'(count0), c);
        chk({tag, ".full"},   int'(full0),  int'(c == 8));
        chk({tag, ".empty"},  int'(empty0), int'(c == 0));
        chk({tag, ".af"},     int'(af0),    int'(c >= 6));
        chk({tag, ".ae"},     int'(ae0),    int'(c <= 2));
        chk({tag, ".ovf"},    int'(ovf0),   int'(m_ovf));
        chk({tag, ".udf"},    int'(udf0),   int'(m_udf));
        chk({tag, ".rdata"},  int'(rdata0), int'(m_rdata0));
        chk({tag, ".count_fwft"}, int'(count1), c);
        chk({tag, ".ovf_fwft"},   int'(ovf1),   int'(m_ovf));
        chk({tag, ".udf_fwft"},   int'(udf1),   int'(m_udf));
        if (c > 0) chk({tag, ".rdata_fwft"}, int'(rdata1), int'(m_q[0]));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        int c, k;
        logic [3:0] v;

        // expectation table for fill-to-overflow and drain-to-underflow
        for (int i = 1; i <= 9; i++) begin
            c = (i > 8) ? 8 : i;
            tbl.push_back('{1'b1, 1'b0, 1'b0, 4'(i), c, c == 8, 1'b0, c >= 6, c <= 2, i == 9, 1'b0, 0});
        end
        for (int j = 1; j <= 9; j++) begin
            c = (j > 8) ? 0 : 8 - j;
            tbl.push_back('{1'b0, 1'b1, 1'b0, 4'd0, c, 1'b0, c == 0, c >= 6, c <= 2, 1'b1, j == 9, (j > 8) ? 8 : j});
        end
        tbl.push_back('{1'b0, 1'b0, 1'b1, 4'd0, 0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 8});

        // reset state
        model_reset();
        #12;
        chk("reset.count", int'(count0), 0);
        chk("reset.empty", int'(empty0), 1);
        chk("reset.full",  int'(full0),  0);
        chk("reset.ae",    int'(ae0),    1);
        chk("reset.af",    int'(af0),    0);
        chk("reset.ovf",   int'(ovf0),   0);
        chk("reset.udf",   int'(udf0),   0);
        chk("reset.rdata", int'(rdata0), 0);
        @(posedge clk_in); #1;
        rst_n = 1'b1;

        // table-driven fill/drain
        k = 0;
        foreach (tbl[i]) begin
            step(tbl[i].wr, tbl[i].rd, tbl[i].clr, tbl[i].wd);
            chk($sformatf("tbl%0d.count", i), int'(count0), tbl[i].cnt);
            chk($sformatf("tbl%0d.full", i),  int'(full0),  int'(tbl[i].full));
            chk($sformatf("tbl%0d.empty", i), int'(empty0), int'(tbl[i].empty));
            chk($sformatf("tbl%0d.af", i),    int'(af0),    int'(tbl[i].af));
            chk($sformatf("tbl%0d.ae", i),    int'(ae0),    int'(tbl[i].ae));
            chk($sformatf("tbl%0d.ovf", i),   int'(ovf0),   int'(tbl[i].ovf));
            chk($sformatf("tbl%0d.udf", i),   int'(udf0),   int'(tbl[i].udf));
            chk($sformatf("tbl%0d.rdata", i), int'(rdata0), tbl[i].rdata);
            check_model($sformatf("tblm%0d", i));
        end

        // steady state at count 4 with simultaneous push/pop across several wraps
        for (int i = 0; i < 4; i++) begin
            step(1, 0, 0, 4'(10 + i));
            check_model("fill4");
        end
        v = 4'd14;
        for (int i = 0; i < 20; i++) begin
            step(1, 1, 0, v);
            v = v + 4'd1;
            check_model($sformatf("steady%0d", i));
        end
        for (int i = 0; i < 4; i++) begin
            step(0, 1, 0, 4'd0);
            check_model("drain4");
        end

        // simultaneous request while empty, then clear the error flags
        step(1, 1, 0, 4'd5);
        chk("empty_rw.count", int'(count0), 1);
        chk("empty_rw.udf",   int'(udf0),   1);
        check_model("empty_rw");
        step(0, 0, 1, 4'd0);
        chk("clr.ovf", int'(ovf0), 0);
        chk("clr.udf", int'(udf0), 0);
        check_model("clr");

        // fall-through visibility
        step(0, 1, 0, 4'd0);
        check_model("fwft_pre");
        step(1, 0, 0, 4'hA);
        chk("fwft.head_a", int'(rdata1), 10);
        step(1, 0, 0, 4'hB);
        chk("fwft.hold_a", int'(rdata1), 10);
        step(0, 1, 0, 4'd0);
        chk("fwft.next_b", int'(rdata1), 11);
        check_model("fwft");
        step(0, 1, 0, 4'd0);
        check_model("fwft_drain");

        // randomized traffic against the model
        for (int i = 0; i < 400; i++) begin
            step(($urandom_range(0, 99) < 55), ($urandom_range(0, 99) < 45),
                 ($urandom_range(0, 99) < 8), 4'($urandom));
            check_model($sformatf("rnd%0d", i));
        end

        // overflow set, then asynchronous reset mid-cycle at count 5
        while (m_q.size() < 8) step(1, 0, 0, 4'($urandom));
        step(1, 0, 0, 4'd7);
        while (m_q.size() > 5) step(0, 1, 0, 4'd0);
        check_model("pre_rst");
        chk("pre_rst.ovf", int'(ovf0), 1);
        #2;
        rst_n = 1'b0;
        #1;
        model_reset();
        chk("async_rst.count", int'(count0), 0);
        chk("async_rst.empty", int'(empty0), 1);
        chk("async_rst.ovf",   int'(ovf0),   0);
        chk("async_rst.udf",   int'(udf0),   0);
        chk("async_rst.count_fwft", int'(count1), 0);
        @(posedge clk_in); #1;
        rst_n = 1'b1;
        step(1, 0, 0, 4'h3);
        chk("post_rst.fwft", int'(rdata1), 3);
        step(0, 1, 0, 4'd0);
        chk("post_rst.rdata", int'(rdata0), 3);
        check_model("post_rst");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/sync_fifo_flags.md
Name: sync_fifo_flags

Overview:
Single-clock, parametrised successor to the team's 4-bit x 8 FIFO. It adds generic width and depth, an occupancy count, and programmable almost-full/almost-empty thresholds. It also adds sticky overflow/underflow error flags and a selectable first-word-fall-through (FWFT) read mode. It sits between the clock divider domain logic and downstream consumers wherever both sides share clk_in.

Parameters:
WIDTH, 4, data word width in bits (>=1)
DEPTH, 8, number of entries; power of two, >=2
AF_THRESH, DEPTH-2, almost_full asserts when count >= AF_THRESH (1..DEPTH)
AE_THRESH, 2, almost_empty asserts when count <= AE_THRESH (0..DEPTH-1)
FWFT, 0, 0 = standard registered read; 1 = first-word-fall-through

Ports:
clk_in  input  1  system clock, all state on rising edge
rst_n  input  1  reset, asynchronous, active-low
wr_rq  input  1  write request
rd_rq  input  1  read request (pop)
wdata  input  WIDTH  write data
clr_err  input  1  synchronous clear of overflow/underflow
rdata  output  WIDTH  read data
full  output  1  count == DEPTH
empty  output  1  count == 0
almost_full  output  1  count >= AF_THRESH
almost_empty  output  1  count <= AE_THRESH
count  output  $clog2(DEPTH)+1  current occupancy 0..DEPTH
overflow  output  1  sticky: write attempted while full
underflow  output  1  sticky: read attempted while empty

Behaviour:
- Reset (rst_n low, async, takes effect immediately):
  - wptr=0, rptr=0, count=0, rdata=0, overflow=0, underflow=0.
  - Outputs: empty=1, almost_empty=1, full=0, almost_full=0 (AF_THRESH>=1).
  - Memory contents are not reset.
- Pointers:
  - Each pointer is $clog2(DEPTH) bits and wraps from DEPTH-1 to 0.
  - count is a separate register.
- Write accepted iff wr_rq && !full at the edge:
  - mem[wptr]<=wdata, wptr+1.
- Read accepted iff rd_rq && !empty at the edge:
  - rptr+1.
- count update:
  - +1 for a write only; -1 for a read only; unchanged when both or neither are accepted.
- Simultaneous wr_rq+rd_rq:
  - When full: read accepted, write rejected; overflow sets; count becomes DEPTH-1.
  - When empty: write accepted, read rejected; underflow sets; count becomes 1.
  - Otherwise: both accepted, count unchanged.
- Status flags:
  - full, empty, almost_full and almost_empty are decoded from the registered count only, with no combinational path from wr_rq/rd_rq.
  - They change the same edge count changes.
- Error flags:
  - overflow<=1 on wr_rq && full; underflow<=1 on rd_rq && empty.
  - clr_err clears both on the next edge; a new error on the same edge takes priority (flag stays 1).
- FWFT=0:
  - On an accepted read, rdata<=mem[rptr] at that edge, so data is visible one cycle after the request.
  - rdata holds its value otherwise, including on rejected reads.
- FWFT=1:
  - rdata = mem[rptr] continuously; head word is visible in the cycle after it is written into an empty FIFO.
  - An accepted read advances to the next word.
  - rdata is don't-care while empty.
- Wrap-around: data order is preserved across pointer wrap; count never exceeds DEPTH and never goes below 0.
- Reset mid-operation: all stored words are discarded (empty=1); the first post-reset write lands at address 0.

Test Plan:
1. Reset, then write 8 words 1..8 with no reads (WIDTH=4, DEPTH=8) -> count 1..8, almost_full from count 6, full at 8, then 9th write (wdata=9) -> full stays 1, overflow=1, count=8.
2. From full, read 8 times, FWFT=0 -> rdata 1..8 each one cycle after its rd_rq, almost_empty from count 2, empty=1 at 0; extra read -> underflow=1, rdata holds 8.
3. Steady state at count=4, wr_rq=rd_rq=1 for 20 cycles with incrementing wdata -> count stays 4, pointers wrap at least twice, output order matches write order.
4. Empty FIFO, wr_rq=rd_rq=1 one cycle -> count=1, underflow=1; next cycle clr_err=1 with no errors -> overflow=underflow=0.
5. FWFT=1: write 0xA into empty FIFO -> rdata=0xA the following cycle before any rd_rq; write 0xB, pulse rd_rq -> rdata=0xB next cycle.
6. At count=5, assert rst_n low mid-cycle -> empty=1, count=0, flags cleared immediately; after release, write 0x3 then read -> rdata=0x3.
